// File: rtl/param_master_port.sv
// Parametrised serial bus master port: arbitration, MSB-first address/data shifting, bursts, split wait.
// Optional NCK retry in the response phase is built when PARAM_MASTER_PORT_RETRY_EN is defined.
module param_master_port #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int LEN_W     = 3,
  parameter int SPLIT_TMO = 255
) (
  input  logic              clk,
  input  logic              reset,
  output logic              addr,
  output logic              wdata,
  input  logic              rdata,
  input  logic [1:0]        response,
  output logic              bus_req,
  input  logic              grant,
  output logic              util,
  output logic              addr_en,
  output logic              wdata_en,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              req_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic [2:0]        state_dbg
);

  localparam int BIT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
  localparam int TMO_W   = $clog2(SPLIT_TMO + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(SPLIT_TMO);
  localparam logic [1:0] RSP_NCK = 2'b00, RSP_BUSY = 2'b01, RSP_OK = 2'b10, RSP_DONE = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_RESP, S_DATA, S_FIN, S_SPLIT} state_t;

  state_t            state, state_nxt;
  logic              write_q, bus_own;
  logic [ADDR_W-1:0] addr_sr;
  logic [DATA_W-1:0] data_sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic [LEN_W-1:0]  beat_cnt;
  logic [TMO_W-1:0]  tmo_cnt;

  logic accept, own_set, own_clr, sh_addr, sh_data, cnt_inc, cnt_clr;
  logic beat_end, beat_dec, tmo_clr, tmo_inc, retry_inc;

`ifdef PARAM_MASTER_PORT_RETRY_EN
  logic [1:0]        retry_cnt;
  logic [ADDR_W-1:0] addr_q;
`endif

  // Request handshake: a request transfers on a clk edge where req_valid and req_ready are both
  // high; req_ready is high exactly in IDLE, so requests made while busy are dropped, not queued.
  assign req_ready = (state == S_IDLE);
  assign bus_req   = (state == S_REQ);
  assign util      = bus_own;
  assign addr_en   = bus_own;
  assign wdata_en  = bus_own;
  assign addr      = (state == S_ADDR) ? addr_sr[ADDR_W-1] : 1'b0;
  assign wdata     = (state == S_DATA && write_q) ? data_sr[DATA_W-1] : 1'b0;
  assign state_dbg = state;

  // wr_pop, done and err fire in the cycle whose edge captures data or leaves the transfer.
  always_comb begin
    state_nxt = state;
    accept = 1'b0; own_set = 1'b0; own_clr = 1'b0; sh_addr = 1'b0; sh_data = 1'b0;
    cnt_inc = 1'b0; cnt_clr = 1'b0; beat_end = 1'b0; beat_dec = 1'b0;
    tmo_clr = 1'b0; tmo_inc = 1'b0; retry_inc = 1'b0;
    wr_pop = 1'b0; done = 1'b0; err = 1'b0;
    case (state)
      S_IDLE: if (req_valid) begin
        accept    = 1'b1;
        state_nxt = S_REQ;
      end
      S_REQ: if (grant) begin
        own_set   = 1'b1;
        state_nxt = S_ADDR;
      end
      S_ADDR: begin
        sh_addr = 1'b1;
        if (bit_cnt == ADDR_LAST) begin
          cnt_clr   = 1'b1;
          state_nxt = S_RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_RESP: case (response)
        RSP_OK: begin
          wr_pop    = write_q;
          state_nxt = S_DATA;
        end
        RSP_BUSY: begin
          own_clr   = 1'b1;
          tmo_clr   = 1'b1;
          state_nxt = S_SPLIT;
        end
        RSP_NCK: begin
          own_clr = 1'b1;
`ifdef PARAM_MASTER_PORT_RETRY_EN
          if (retry_cnt == 2'd2) begin
            err       = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            retry_inc = 1'b1;
            state_nxt = S_REQ;
          end
`else
          err       = 1'b1;
          state_nxt = S_IDLE;
`endif
        end
        default: ;
      endcase
      S_DATA: begin
        sh_data = 1'b1;
        if (bit_cnt == DATA_LAST) begin
          beat_end = 1'b1;
          cnt_clr  = 1'b1;
          if (beat_cnt != '0) begin
            beat_dec = 1'b1;
            wr_pop   = write_q;
          end else begin
            state_nxt = S_FIN;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_FIN: begin
        if (response == RSP_DONE) begin
          done      = 1'b1;
          own_clr   = 1'b1;
          state_nxt = S_IDLE;
        end else if (response == RSP_NCK) begin
          err       = 1'b1;
          own_clr   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_SPLIT: begin
        own_set = grant;
        if (grant && response == RSP_OK) begin
          wr_pop    = write_q;
          state_nxt = S_DATA;
        end else if (tmo_cnt == TMO_LAST) begin
          err       = 1'b1;
          own_set   = 1'b0;
          own_clr   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      write_q  <= 1'b0;
      bus_own  <= 1'b0;
      addr_sr  <= '0;
      data_sr  <= '0;
      bit_cnt  <= '0;
      beat_cnt <= '0;
      tmo_cnt  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_valid <= beat_end && !write_q;
      if (own_clr)      bus_own <= 1'b0;
      else if (own_set) bus_own <= 1'b1;
      if (accept) begin
        write_q  <= req_write;
        addr_sr  <= req_addr;
        beat_cnt <= req_len;
      end else begin
        if (sh_addr)  addr_sr  <= addr_sr << 1;
        if (beat_dec) beat_cnt <= beat_cnt - 1'b1;
`ifdef PARAM_MASTER_PORT_RETRY_EN
        if (retry_inc) addr_sr <= addr_q;
`endif
      end
      // A fresh write beat is loaded over the final shift of the previous one.
      if (wr_pop)       data_sr <= wr_data;
      else if (sh_data) data_sr <= write_q ? (data_sr << 1) : {data_sr[DATA_W-2:0], rdata};
      if (beat_end && !write_q) rd_data <= {data_sr[DATA_W-2:0], rdata};
      if (cnt_clr)      bit_cnt <= '0;
      else if (cnt_inc) bit_cnt <= bit_cnt + 1'b1;
      if (tmo_clr)      tmo_cnt <= '0;
      else if (tmo_inc) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

`ifdef PARAM_MASTER_PORT_RETRY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      retry_cnt <= '0;
      addr_q    <= '0;
    end else if (accept) begin
      retry_cnt <= '0;
      addr_q    <= req_addr;
    end else if (retry_inc) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_param_master_port.sv
// Bench for param_master_port: acts as arbiter and slave, predicting each cycle from the protocol timeline.
// Retry scenarios follow PARAM_MASTER_PORT_RETRY_EN when it is defined for the build.
module tb_param_master_port;

  localparam int ADDR_W = 16, DATA_W = 8, LEN_W = 3, SPLIT_TMO = 8;
  localparam logic [1:0] RSP_NCK = 2'b00, RSP_BUSY = 2'b01, RSP_OK = 2'b10, RSP_DONE = 2'b11;
  localparam int K_NORM = 0, K_SPLIT = 1, K_TMO = 2, K_NCK = 3, K_FNCK = 4;

  logic clk = 1'b0, reset = 1'b1;
  logic addr, wdata, rdata, bus_req, grant, util, addr_en, wdata_en;
  logic [1:0] response;
  logic req_valid, req_write, req_ready, wr_pop, rd_valid, done, err;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic [2:0] state_dbg;

  int n_cmp = 0, n_err = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] txn_w [8];
  logic s_addr, s_wdata;

  param_master_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .SPLIT_TMO(SPLIT_TMO)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .rdata(rdata), .response(response),
    .bus_req(bus_req), .grant(grant), .util(util), .addr_en(addr_en), .wdata_en(wdata_en),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .req_ready(req_ready), .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data),
    .rd_valid(rd_valid), .done(done), .err(err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected control vector: {req_ready, bus_req, util, addr_en, wdata_en, wr_pop, rd_valid, done, err}
  function automatic logic [8:0] ev(input bit rr, input bit br, input bit u, input bit pop,
                                    input bit rv, input bit dn, input bit er);
    return {rr, br, u, u, u, pop, rv, dn, er};
  endfunction

  // One bus cycle: inputs are already driven; sample mid-cycle, then move just past the next edge.
  task automatic step(input logic [8:0] exp, input string tag);
    logic [DATA_W-1:0] exp_w;
    @(negedge clk);
    s_addr  = addr;
    s_wdata = wdata;
    check_val(tag, 32'({req_ready, bus_req, util, addr_en, wdata_en, wr_pop, rd_valid, done, err}),
              32'(exp));
    if (exp[2]) begin
      exp_w = exp_q.pop_front();
      check_val("rd_data", 32'(rd_data), 32'(exp_w));
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_check(input string tag);
    req_valid = 1'b0; grant = 1'b0; response = RSP_DONE;
    step(ev(1, 0, 0, 0, 0, 0, 0), tag);
  endtask

  task automatic run_txn(input bit wr, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len,
                         input int kind, input int nck_n, input int sd_in, input int abort_beat);
    int nbeats, pop_idx, att, sd, gd;
    bit rv_next, u_cur, last, pop, gwo;
    logic [ADDR_W-1:0] got_a;
    logic [DATA_W-1:0] got_w;
    nbeats  = int'(len) + 1;
    pop_idx = 0;
    wr_data = txn_w[0];
    req_valid = 1'b1; req_write = wr; req_addr = a; req_len = len;
    grant = 1'b0; response = RSP_DONE;
    step(ev(1, 0, 0, 0, 0, 0, 0), "accept");
    req_valid = 1'b0; req_write = ~wr; req_addr = ADDR_W'($urandom); req_len = LEN_W'($urandom);
    att = 0;
    while (1) begin
      gd = $urandom_range(0, 4);
      for (int i = 0; i < gd; i++) begin
        req_valid = 1'($urandom_range(0, 1));
        step(ev(0, 1, 0, 0, 0, 0, 0), "req_wait");
      end
      req_valid = 1'b0; grant = 1'b1;
      step(ev(0, 1, 0, 0, 0, 0, 0), "req_grant");
      got_a = '0;
      for (int i = 0; i < ADDR_W; i++) begin
        grant    = 1'($urandom_range(0, 1));
        response = 2'($urandom_range(0, 3));
        step(ev(0, 0, 1, 0, 0, 0, 0), "addr_phase");
        got_a = {got_a[ADDR_W-2:0], s_addr};
      end
      check_val("addr_word", 32'(got_a), 32'(a));
      grant = 1'b0; response = RSP_DONE;
      repeat ($urandom_range(0, 2)) step(ev(0, 0, 1, 0, 0, 0, 0), "resp_ignore_done");
      if (kind == K_NCK && att < nck_n) begin
        response = RSP_NCK;
`ifdef PARAM_MASTER_PORT_RETRY_EN
        if (att < 2) begin
          step(ev(0, 0, 1, 0, 0, 0, 0), "resp_nck_retry");
          response = RSP_DONE;
          att++;
          continue;
        end
`endif
        step(ev(0, 0, 1, 0, 0, 0, 1), "resp_nck_err");
        idle_check("nck_idle");
        return;
      end
      break;
    end
    if (kind == K_SPLIT || kind == K_TMO) begin
      response = RSP_BUSY;
      step(ev(0, 0, 1, 0, 0, 0, 0), "resp_busy");
      response = RSP_DONE;
      if (kind == K_TMO) begin
        for (int i = 0; i <= SPLIT_TMO; i++) begin
          response = $urandom_range(0, 1) ? RSP_OK : RSP_DONE;
          step(ev(0, 0, 0, 0, 0, 0, i == SPLIT_TMO), "split_tmo");
        end
        idle_check("tmo_idle");
        return;
      end
      sd    = (sd_in >= 0) ? sd_in : $urandom_range(1, SPLIT_TMO);
      gwo   = (sd >= 2) && ($urandom_range(0, 1) == 1);
      u_cur = 1'b0;
      for (int i = 0; i < sd; i++) begin
        grant = gwo && (i == sd - 1);
        step(ev(0, 0, u_cur, 0, 0, 0, 0), "split_wait");
        if (grant) u_cur = 1'b1;
      end
      grant = 1'b1; response = RSP_OK;
      step(ev(0, 0, u_cur, wr, 0, 0, 0), "split_regrant");
    end else begin
      response = RSP_OK;
      step(ev(0, 0, 1, wr, 0, 0, 0), "resp_ok");
    end
    grant = 1'b0; response = RSP_DONE;
    if (wr) begin
      pop_idx++;
      if (pop_idx < 8) wr_data = txn_w[pop_idx];
    end
    rv_next = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      got_w = '0;
      for (int i = 0; i < DATA_W; i++) begin
        if (b == abort_beat && i == 3) begin
          reset = 1'b1;
          @(negedge clk); @(posedge clk); #1;
          reset = 1'b0; req_valid = 1'b0; grant = 1'b0;
          exp_q.delete();
          step(ev(1, 0, 0, 0, 0, 0, 0), "rst_ctl");
          check_val("rst_rd_data", 32'(rd_data), 32'd0);
          return;
        end
        rdata     = txn_w[b][DATA_W-1-i];
        last      = (i == DATA_W - 1);
        pop       = wr && last && (b < nbeats - 1);
        req_valid = 1'($urandom_range(0, 1));
        grant     = 1'($urandom_range(0, 1));
        response  = 2'($urandom_range(0, 3));
        step(ev(0, 0, 1, pop, rv_next, 0, 0), "data_phase");
        rv_next = !wr && last;
        if (wr) got_w = {got_w[DATA_W-2:0], s_wdata};
        if (pop) begin
          pop_idx++;
          if (pop_idx < 8) wr_data = txn_w[pop_idx];
        end
      end
      if (wr) check_val("wdata_word", 32'(got_w), 32'(txn_w[b]));
      else    exp_q.push_back(txn_w[b]);
    end
    req_valid = 1'b0; grant = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      response = RSP_OK;
      step(ev(0, 0, 1, 0, rv_next, 0, 0), "fin_wait");
      rv_next = 1'b0;
    end
    if (kind == K_FNCK) begin
      response = RSP_NCK;
      step(ev(0, 0, 1, 0, rv_next, 0, 1), "fin_nck");
    end else begin
      response = RSP_DONE;
      step(ev(0, 0, 1, 0, rv_next, 1, 0), "fin_done");
    end
    idle_check("done_idle");
  endtask

  initial begin
    int kd;
    rdata = 1'b0; response = RSP_DONE; grant = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    step(ev(1, 0, 0, 0, 0, 0, 0), "reset_ctl");
    check_val("reset_rd_data", 32'(rd_data), 32'd0);

    txn_w[0] = 8'h3C;
    run_txn(1'b1, 16'hA5C3, 3'd0, K_NORM, 1, -1, -1);
    txn_w[0] = 8'h11; txn_w[1] = 8'h22; txn_w[2] = 8'h33; txn_w[3] = 8'h44;
    run_txn(1'b0, 16'h1234, 3'd3, K_NORM, 1, -1, -1);
    run_txn(1'b1, 16'h0F0F, 3'd1, K_SPLIT, 1, SPLIT_TMO, -1);
    run_txn(1'b0, 16'hF00D, 3'd2, K_SPLIT, 1, 1, -1);
    run_txn(1'b0, 16'hBEEF, 3'd0, K_TMO, 1, -1, -1);
    run_txn(1'b1, 16'h8001, 3'd0, K_NCK, 1, -1, -1);
`ifdef PARAM_MASTER_PORT_RETRY_EN
    run_txn(1'b1, 16'h4242, 3'd1, K_NCK, 2, -1, -1);
    run_txn(1'b0, 16'h2424, 3'd0, K_NCK, 3, -1, -1);
`endif
    run_txn(1'b0, 16'h7777, 3'd1, K_FNCK, 1, -1, -1);
    for (int k = 0; k < 8; k++) txn_w[k] = DATA_W'($urandom);
    run_txn(1'b0, 16'hC0DE, 3'd3, K_NORM, 1, -1, 1);
    run_txn(1'b1, 16'h5A5A, 3'd7, K_NORM, 1, -1, -1);

    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 8; k++) txn_w[k] = DATA_W'($urandom);
      kd = $urandom_range(0, 9);
      run_txn(1'($urandom_range(0, 1)), ADDR_W'($urandom), LEN_W'($urandom),
              (kd < 5) ? K_NORM : (kd < 7) ? K_SPLIT : (kd == 7) ? K_TMO : (kd == 8) ? K_NCK : K_FNCK,
              $urandom_range(1, 3), -1, -1);
    end
    check_val("rd_queue_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
